// File: rtl/fifo_ff_param_if.sv
// Handshake bundle for fifo_ff_param: producer/consumer side is the master,
// the FIFO itself is the slave.
interface fifo_ff_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int OW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [OW-1:0]    occup;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, occup
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, occup
  );
endinterface

// File: rtl/fifo_ff_param.sv
// Single-clock FIFO of any depth >= 2 with almost flags and optional FWFT read.
// Define FIFO_FF_ERR_CNT_EN to add saturating overflow/underflow counters.
module fifo_ff_param #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int FWFT   = 0,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  fifo_ff_param_if.slave  bus
`ifdef FIFO_FF_ERR_CNT_EN
  ,
  input  logic            err_clr,
  output logic [15:0]     ovf_cnt,
  output logic [15:0]     udf_cnt
`endif
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH) + 1;

  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_ff_param: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_ff_param: DEPTH must be >= 2");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("fifo_ff_param: FWFT must be 0 or 1");
  end
  if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_bad_af
    $error("fifo_ff_param: AF_LVL out of range 1..DEPTH");
  end
  if (AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_ff_param: AE_LVL out of range 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [OW-1:0]    occ_q;
  logic             full_w;
  logic             empty_w;
  logic             wr_acc;
  logic             rd_acc;

  assign full_w  = (occ_q == OW'(DEPTH));
  assign empty_w = (occ_q == '0);
  assign wr_acc  = bus.wr_en && !full_w;
  assign rd_acc  = bus.rd_en && !empty_w;

  // Explicit wrap so non-power-of-two depths never alias unused slots.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_acc && !rd_acc)      occ_q <= occ_q + OW'(1);
      else if (rd_acc && !wr_acc) occ_q <= occ_q - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.wr_data;
  end

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.occup        = occ_q;
  assign bus.almost_full  = (occ_q >= OW'(AF_LVL));
  assign bus.almost_empty = (occ_q <= OW'(AE_LVL));

  if (FWFT != 0) begin : g_fwft
    assign bus.rd_data  = mem[rd_ptr];
    assign bus.rd_valid = !empty_w;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem[rd_ptr];
      end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
  end

`ifdef FIFO_FF_ERR_CNT_EN
  // Clear has priority over a same-cycle increment; both counters saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else if (err_clr) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      if (bus.wr_en && full_w && ovf_cnt != 16'hFFFF)  ovf_cnt <= ovf_cnt + 16'd1;
      if (bus.rd_en && empty_w && udf_cnt != 16'hFFFF) udf_cnt <= udf_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_ff_param.sv
// Self-checking bench for fifo_ff_param: three instances (DEPTH 5 std, DEPTH 16 std,
// DEPTH 4 FWFT) checked against a queue scoreboard and an occupancy model.
module tb_fifo_ff_param;
  logic clk;
  logic rst_n;
  logic err_clr;

  fifo_ff_param_if #(.WIDTH(32), .DEPTH(5))  bus5();
  fifo_ff_param_if #(.WIDTH(32), .DEPTH(16)) bus16();
  fifo_ff_param_if #(.WIDTH(8),  .DEPTH(4))  busf();

`ifdef FIFO_FF_ERR_CNT_EN
  logic [15:0] ovf5, udf5, ovf16, udf16, ovff, udff;
`endif

  fifo_ff_param #(.WIDTH(32), .DEPTH(5), .FWFT(0)) u5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5)
`ifdef FIFO_FF_ERR_CNT_EN
    , .err_clr(err_clr), .ovf_cnt(ovf5), .udf_cnt(udf5)
`endif
  );

  fifo_ff_param #(.WIDTH(32), .DEPTH(16), .FWFT(0), .AF_LVL(14), .AE_LVL(2)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16)
`ifdef FIFO_FF_ERR_CNT_EN
    , .err_clr(err_clr), .ovf_cnt(ovf16), .udf_cnt(udf16)
`endif
  );

  fifo_ff_param #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AF_LVL(4), .AE_LVL(0)) uf (
    .clk(clk), .rst_n(rst_n), .bus(busf)
`ifdef FIFO_FF_ERR_CNT_EN
    , .err_clr(err_clr), .ovf_cnt(ovff), .udf_cnt(udff)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Reference model: per-instance configuration, occupancy and scoreboard queues.
  int          dep  [3] = '{5, 16, 4};
  int          afl  [3] = '{3, 14, 4};
  int          ael  [3] = '{2, 2, 0};
  bit          fwft [3] = '{1'b0, 1'b0, 1'b1};
  logic [31:0] mask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
  int          m_occ[3];
  logic [31:0] last_data[3];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  typedef struct {
    logic        we;
    logic [31:0] wd;
    logic        re;
    int          exp_occ;
    logic        exp_full;
    logic        exp_empty;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vec[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sbPush(input int sel, input logic [31:0] d);
    case (sel)
      0: q0.push_back(d);
      1: q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic sbPop(input int sel, output logic [31:0] d);
    case (sel)
      0: d = q0.pop_front();
      1: d = q1.pop_front();
      default: d = q2.pop_front();
    endcase
  endtask

  task automatic sbFront(input int sel, output logic [31:0] d);
    case (sel)
      0: d = q0[0];
      1: d = q1[0];
      default: d = q2[0];
    endcase
  endtask

  task automatic sampleOut(input int sel, output logic [31:0] data, output logic valid,
                           output int occ, output logic f, output logic e,
                           output logic af, output logic ae);
    case (sel)
      0: begin
        data = bus5.rd_data; valid = bus5.rd_valid; occ = int'(bus5.occup);
        f = bus5.full; e = bus5.empty; af = bus5.almost_full; ae = bus5.almost_empty;
      end
      1: begin
        data = bus16.rd_data; valid = bus16.rd_valid; occ = int'(bus16.occup);
        f = bus16.full; e = bus16.empty; af = bus16.almost_full; ae = bus16.almost_empty;
      end
      default: begin
        data = 32'(busf.rd_data); valid = busf.rd_valid; occ = int'(busf.occup);
        f = busf.full; e = busf.empty; af = busf.almost_full; ae = busf.almost_empty;
      end
    endcase
  endtask

  task automatic driveIdle();
    bus5.wr_en = 1'b0;  bus5.rd_en = 1'b0;  bus5.wr_data = '0;
    bus16.wr_en = 1'b0; bus16.rd_en = 1'b0; bus16.wr_data = '0;
    busf.wr_en = 1'b0;  busf.rd_en = 1'b0;  busf.wr_data = '0;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      m_occ[i] = 0;
      last_data[i] = '0;
    end
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  // One clock cycle on the selected instance, with full model checking.
  task automatic applyStimulus(input int sel, input logic we, input logic [31:0] wd, input logic re);
    logic [31:0] data, exp_d, head;
    logic        valid, f, e, af, ae, wr_ok, rd_ok;
    int          occ;
    driveIdle();
    case (sel)
      0: begin bus5.wr_en = we;  bus5.wr_data = wd;  bus5.rd_en = re;  end
      1: begin bus16.wr_en = we; bus16.wr_data = wd; bus16.rd_en = re; end
      default: begin busf.wr_en = we; busf.wr_data = wd[7:0]; busf.rd_en = re; end
    endcase
    wr_ok = we && (m_occ[sel] < dep[sel]);
    rd_ok = re && (m_occ[sel] > 0);
    exp_d = '0;
    #1;
    if (fwft[sel]) begin
      sampleOut(sel, data, valid, occ, f, e, af, ae);
      checkOutput("fwft_valid", 32'(valid), 32'(m_occ[sel] > 0));
      if (m_occ[sel] > 0) begin
        sbFront(sel, head);
        checkOutput("fwft_head", data, head);
      end
    end
    if (rd_ok) sbPop(sel, exp_d);
    if (wr_ok) sbPush(sel, wd & mask[sel]);
    @(posedge clk);
    #1;
    if (wr_ok && !rd_ok) m_occ[sel]++;
    else if (rd_ok && !wr_ok) m_occ[sel]--;
    sampleOut(sel, data, valid, occ, f, e, af, ae);
    checkOutput("occup", 32'(occ), 32'(m_occ[sel]));
    checkOutput("full", 32'(f), 32'(m_occ[sel] == dep[sel]));
    checkOutput("empty", 32'(e), 32'(m_occ[sel] == 0));
    checkOutput("almost_full", 32'(af), 32'(m_occ[sel] >= afl[sel]));
    checkOutput("almost_empty", 32'(ae), 32'(m_occ[sel] <= ael[sel]));
    if (!fwft[sel]) begin
      checkOutput("rd_valid", 32'(valid), 32'(rd_ok));
      if (rd_ok) begin
        checkOutput("rd_data", data, exp_d);
        last_data[sel] = exp_d;
      end else begin
        checkOutput("rd_data_hold", data, last_data[sel]);
      end
    end
  endtask

  initial begin
    logic [31:0] data;
    logic        valid, f, e, af, ae;
    int          occ;

    for (int i = 0; i < 5; i++)
      vec[i] = '{1'b1, 32'((i + 1) * 17), 1'b0, i + 1, (i == 4), 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 5; i++)
      vec[5 + i] = '{1'b0, 32'h0, 1'b1, 4 - i, 1'b0, (i == 4), 1'b1, 32'((i + 1) * 17)};

    err_clr = 1'b0;
    driveIdle();
    modelReset();
    rst_n = 1'b0;
    #12;
    for (int s = 0; s < 3; s++) begin
      sampleOut(s, data, valid, occ, f, e, af, ae);
      checkOutput("rst_occup", 32'(occ), 32'd0);
      checkOutput("rst_empty", 32'(e), 32'd1);
      checkOutput("rst_full", 32'(f), 32'd0);
      checkOutput("rst_af", 32'(af), 32'd0);
      checkOutput("rst_ae", 32'(ae), 32'd1);
      checkOutput("rst_valid", 32'(valid), 32'd0);
    end
    sampleOut(0, data, valid, occ, f, e, af, ae);
    checkOutput("rst_rd_data", data, 32'd0);
    rst_n = 1'b1;

    $display("[TB] table: fill and drain DEPTH=5");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, vec[i].we, vec[i].wd, vec[i].re);
      sampleOut(0, data, valid, occ, f, e, af, ae);
      checkOutput($sformatf("t1_occ[%0d]", i), 32'(occ), 32'(vec[i].exp_occ));
      checkOutput($sformatf("t1_full[%0d]", i), 32'(f), 32'(vec[i].exp_full));
      checkOutput($sformatf("t1_empty[%0d]", i), 32'(e), 32'(vec[i].exp_empty));
      if (vec[i].exp_valid)
        checkOutput($sformatf("t1_data[%0d]", i), data, vec[i].exp_data);
    end

    $display("[TB] pointer wrap with simultaneous write/read");
    applyStimulus(0, 1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1'b1, 32'h200 + 32'(i), 1'b1);
    applyStimulus(0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 1'b1, 32'h400 + 32'(i), 1'b0);
      applyStimulus(0, 1'b0, 32'h0, 1'b1);
    end

    $display("[TB] write rejected while full even with a read");
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'b1, 32'h301 + 32'(i), 1'b0);
    applyStimulus(0, 1'b1, 32'hDEADBEEF, 1'b1);
    sampleOut(0, data, valid, occ, f, e, af, ae);
    checkOutput("t3_occ", 32'(occ), 32'd4);
    checkOutput("t3_data", data, 32'h301);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b0, 32'h0, 1'b1);
    sampleOut(0, data, valid, occ, f, e, af, ae);
    checkOutput("t3_last", data, 32'h305);
    applyStimulus(0, 1'b0, 32'h0, 1'b1);

    $display("[TB] almost flags DEPTH=16");
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1, 1'b1, 32'hA000 + 32'(i), 1'b0);
      sampleOut(1, data, valid, occ, f, e, af, ae);
      checkOutput($sformatf("t4_ae[%0d]", i), 32'(ae), 32'(i <= 2));
      checkOutput($sformatf("t4_af[%0d]", i), 32'(af), 32'(i >= 14));
    end
    checkOutput("t4_full", 32'(f), 32'd1);
    for (int i = 0; i < 16; i++) applyStimulus(1, 1'b0, 32'h0, 1'b1);

    $display("[TB] first-word-fall-through latency");
    applyStimulus(2, 1'b1, 32'hA5, 1'b0);
    sampleOut(2, data, valid, occ, f, e, af, ae);
    checkOutput("t5_fwft_valid", 32'(valid), 32'd1);
    checkOutput("t5_fwft_data", data, 32'hA5);
    applyStimulus(2, 1'b0, 32'h0, 1'b1);
    applyStimulus(0, 1'b1, 32'hA5, 1'b0);
    sampleOut(0, data, valid, occ, f, e, af, ae);
    checkOutput("t5_std_novalid", 32'(valid), 32'd0);
    applyStimulus(0, 1'b0, 32'h0, 1'b1);
    sampleOut(0, data, valid, occ, f, e, af, ae);
    checkOutput("t5_std_data", data, 32'hA5);
    checkOutput("t5_std_valid", 32'(valid), 32'd1);

    $display("[TB] random traffic");
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 300; i++)
        applyStimulus(s, 1'($urandom_range(1)), $urandom, 1'($urandom_range(1)));

    $display("[TB] asynchronous reset mid-operation");
    for (int s = 0; s < 3; s++)
      while (m_occ[s] > 0) applyStimulus(s, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 32'h600 + 32'(i), 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 1'b1);
    applyStimulus(0, 1'b1, 32'h700, 1'b0);
    driveIdle();
    #2;
    rst_n = 1'b0;
    #1;
    sampleOut(0, data, valid, occ, f, e, af, ae);
    checkOutput("t6_empty", 32'(e), 32'd1);
    checkOutput("t6_occ", 32'(occ), 32'd0);
    checkOutput("t6_ae", 32'(ae), 32'd1);
    checkOutput("t6_data", data, 32'd0);
    modelReset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    applyStimulus(0, 1'b0, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 32'h800, 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 1'b1);

`ifdef FIFO_FF_ERR_CNT_EN
    $display("[TB] error counters");
    checkOutput("ovf_start", 32'(ovf5), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'b1, 32'h900 + 32'(i), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 32'hBAD, 1'b0);
    checkOutput("ovf_cnt", 32'(ovf5), 32'd3);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1'b0, 32'h0, 1'b1);
    checkOutput("udf_cnt", 32'(udf5), 32'd2);
    err_clr = 1'b1;
    applyStimulus(0, 1'b0, 32'h0, 1'b1);
    err_clr = 1'b0;
    checkOutput("ovf_clr", 32'(ovf5), 32'd0);
    checkOutput("udf_clr", 32'(udf5), 32'd0);
`endif

    driveIdle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
